multibyte_add_sequencer: RTL

Sequencer that sits directly upstream of the team's combinational 8-bit ripple-carry adder and consumes its result. It accepts wide operand pairs over a valid/ready handshake and feeds the adder one byte slice per cycle, LSB first, carrying between slices in a register. It assembles the wide sum and returns it with carry-out and signed overflow over a second valid/ready handshake. Add and subtract are supported; subtract is A + ~B + 1.

---
 rtl/multibyte_add_sequencer_pkg.sv | 12 +
 rtl/rca8.sv | 23 ++
 rtl/multibyte_add_sequencer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/multibyte_add_sequencer_pkg.sv
// Shared definitions for the multi-byte add sequencer: FSM encoding and slice width.
package multibyte_add_sequencer_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } seq_state_e;

endpackage

// File: rtl/rca8.sv
// Existing combinational 8-bit ripple-carry adder that the sequencer drives one slice per cycle.
module rca8 (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       cin_i,
    output logic [7:0] sum_o,
    output logic       cout_o
);

    logic [8:0] c;

    always_comb begin
        c      = '0;
        sum_o  = '0;
        c[0]   = cin_i;
        for (int i = 0; i < 8; i++) begin
            sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
            c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
        end
        cout_o = c[8];
    end

endmodule

// File: rtl/multibyte_add_sequencer.sv
// Feeds an external 8-bit adder one byte per cycle (LSB first) and assembles a wide sum,
// carry-out and signed overflow, with valid/ready handshakes on both sides.
import multibyte_add_sequencer_pkg::*;

module multibyte_add_sequencer #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [8*NBYTES-1:0]   in_a,
    input  logic [8*NBYTES-1:0]   in_b,
    input  logic                  in_cin,
    input  logic                  in_sub,
    output logic [7:0]            add_a,
    output logic [7:0]            add_b,
    output logic                  add_cin,
    input  logic [7:0]            add_sum,
    input  logic                  add_cout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [8*NBYTES-1:0]   out_sum,
    output logic                  out_cout,
    output logic                  out_ovf,
    output logic                  busy
);

    localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    // Handshake rule: a transfer happens on a rising edge where valid and ready are both
    // high; valid-side signals are only sampled on that edge.

    seq_state_e                      state_q;
    logic [IDX_W-1:0]                idx_q;
    logic                            carry_q;
    logic [NBYTES-1:0][BYTE_W-1:0]   a_q;
    logic [NBYTES-1:0][BYTE_W-1:0]   b_q;
    logic [NBYTES-1:0][BYTE_W-1:0]   sum_q;
    logic                            in_ready_q;
    logic                            out_valid_q;
    logic                            busy_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q        <= in_a;
                        // Subtract is A + ~B + 1: store B inverted and force the carry in.
                        b_q        <= in_sub ? ~in_b : in_b;
                        carry_q    <= in_sub | in_cin;
                        idx_q      <= '0;
                        state_q    <= S_RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                S_RUN: begin
                    sum_q[idx_q] <= add_sum;
                    carry_q      <= add_cout;
                    if (idx_q == LAST_IDX) begin
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (state_q == S_RUN) begin
            add_a   = a_q[idx_q];
            add_b   = b_q[idx_q];
            add_cin = carry_q;
        end
    end

    // Result outputs are only meaningful in DONE; elsewhere they read as zero.
    always_comb begin
        out_sum  = '0;
        out_cout = 1'b0;
        out_ovf  = 1'b0;
        if (state_q == S_DONE) begin
            out_sum  = sum_q;
            out_cout = carry_q;
            out_ovf  = (a_q[NBYTES-1][BYTE_W-1] == b_q[NBYTES-1][BYTE_W-1]) &&
                       (sum_q[NBYTES-1][BYTE_W-1] != a_q[NBYTES-1][BYTE_W-1]);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

endmodule
